// File: rtl/ex_mem_pipe_pkg.sv
// Shared definitions for the execute/memory pipeline boundary of the 16-bit core:
// datapath widths, halt sequencing states and the registered control/data bundles.
package ex_mem_pipe_pkg;

  localparam int DATA_W     = 16;
  localparam int REG_ADDR_W = 3;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    DUMP      = 2'd2,
    HALTED    = 2'd3
  } haltState_e;

  typedef struct packed {
    logic                  valid;
    logic                  memRead;
    logic                  memWrite;
    logic                  regWrite;
    logic                  wbSel;
    logic [REG_ADDR_W-1:0] writeReg;
  } ctrl_t;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } data_t;

  localparam int CTRL_W   = $bits(ctrl_t);
  localparam int DBUNDLE_W = $bits(data_t);

  // A bubble carries no work: not valid and every enable cleared.
  localparam ctrl_t CTRL_BUBBLE = '0;

  // Only word accesses exist, so any odd byte address is misaligned.
  function automatic logic isMisaligned(input logic [DATA_W-1:0] addr);
    return addr[0];
  endfunction

endpackage

// File: rtl/ex_mem_pipe_field_reg.sv
// Width-parameterised pipeline register with synchronous reset, hold and bubble-load.
// Priority at each edge: rst > hold > bubble > load.
module pipe_field_reg #(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] BUBBLE_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic             bubble,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (hold) begin
      q <= q;
    end else if (bubble) begin
      q <= BUBBLE_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ex_mem_pipe.sv
// EX/MEM pipeline register: captures execute results, gates memory and register-file
// enables on validity and alignment, and sequences HALT through pending, dump and halted.
module ex_mem_pipe
  import ex_mem_pipe_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     ex_out,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic                  ex_reg_write,
  input  logic                  ex_wb_sel,
  input  logic [REG_ADDR_W-1:0] ex_write_reg,
  input  logic                  ex_halt,
  input  logic                  flush_in,
  input  logic                  mem_busy,
  output logic [DATA_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  reg_write,
  output logic                  wb_sel,
  output logic [REG_ADDR_W-1:0] write_reg,
  output logic                  valid_out,
  output logic                  align_err,
  output logic                  dump,
  output logic                  halted,
  output logic                  stall_out
);

  haltState_e state;
  logic       pendingFlush;
  logic       dumpQ;
  logic       haltedQ;
  logic       holdCond;
  logic       flushNow;
  logic       regHold;
  logic       regBubble;
  logic       haltLoad;
  logic       mis;
  ctrl_t      ctrlD;
  ctrl_t      ctrlQ;
  data_t      dataD;
  data_t      dataQ;

  assign holdCond = mem_busy | (state != RUN);
  assign flushNow = flush_in | pendingFlush;

  // DUMP is the one non-RUN state whose edge must replace the entry with a bubble.
  assign regHold   = holdCond & (state != DUMP);
  assign regBubble = flushNow | (state == DUMP);
  assign haltLoad  = ~holdCond & ~flushNow & in_valid & ex_halt;

  always_comb begin
    ctrlD          = CTRL_BUBBLE;
    ctrlD.valid    = in_valid;
    ctrlD.memRead  = ex_mem_read;
    ctrlD.memWrite = ex_mem_write;
    ctrlD.regWrite = ex_reg_write;
    ctrlD.wbSel    = ex_wb_sel;
    ctrlD.writeReg = ex_write_reg;
    dataD.addr     = ex_out;
    dataD.wdata    = ex_store_data;
  end

  pipe_field_reg #(
    .WIDTH      (CTRL_W),
    .BUBBLE_VAL (CTRL_BUBBLE)
  ) u_ctrlReg (
    .clk    (clk),
    .rst    (rst),
    .hold   (regHold),
    .bubble (regBubble),
    .d      (ctrlD),
    .q      (ctrlQ)
  );

  pipe_field_reg #(
    .WIDTH      (DBUNDLE_W),
    .BUBBLE_VAL ('0)
  ) u_dataReg (
    .clk    (clk),
    .rst    (rst),
    .hold   (regHold),
    .bubble (regBubble),
    .d      (dataD),
    .q      (dataQ)
  );

  // A flush arriving while the entry is held is remembered until the entry can move.
  always_ff @(posedge clk) begin
    if (rst) begin
      pendingFlush <= 1'b0;
    end else if (!holdCond) begin
      pendingFlush <= 1'b0;
    end else if (flush_in && state != HALTED) begin
      pendingFlush <= 1'b1;
    end
  end

  // NOTE: every control register is reset, and dump/halted are registered beside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      dumpQ   <= 1'b0;
      haltedQ <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (haltLoad) state <= HALT_PEND;
        end
        HALT_PEND: begin
          if (!mem_busy) begin
            state <= DUMP;
            dumpQ <= 1'b1;
          end
        end
        DUMP: begin
          state   <= HALTED;
          dumpQ   <= 1'b0;
          haltedQ <= 1'b1;
        end
        HALTED: begin
          state <= HALTED;
        end
        default: begin
          state   <= RUN;
          dumpQ   <= 1'b0;
          haltedQ <= 1'b0;
        end
      endcase
    end
  end

  assign mis       = isMisaligned(dataQ.addr);
  assign mem_addr  = dataQ.addr;
  assign mem_wdata = dataQ.wdata;
  assign mem_read  = ctrlQ.valid & ctrlQ.memRead & ~mis;
  assign mem_write = ctrlQ.valid & ctrlQ.memWrite & ~mis;
  assign reg_write = ctrlQ.valid & ctrlQ.regWrite & ~mis;
  assign align_err = ctrlQ.valid & (ctrlQ.memRead | ctrlQ.memWrite) & mis;
  assign wb_sel    = ctrlQ.wbSel;
  assign write_reg = ctrlQ.writeReg;
  assign valid_out = ctrlQ.valid;
  assign dump      = dumpQ;
  assign halted    = haltedQ;
  assign stall_out = holdCond;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// Scoreboard bench for ex_mem_pipe: the driver queues hand-computed expectations per
// edge, and a negedge monitor pops and compares every output.
module tb_ex_mem_pipe;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [15:0] ex_out;
  logic [15:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_reg_write;
  logic        ex_wb_sel;
  logic [2:0]  ex_write_reg;
  logic        ex_halt;
  logic        flush_in;
  logic        mem_busy;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic        reg_write;
  logic        wb_sel;
  logic [2:0]  write_reg;
  logic        valid_out;
  logic        align_err;
  logic        dump;
  logic        halted;
  logic        stall_out;

  typedef struct {
    logic        valid;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        rd;
    logic        wr;
    logic        rw;
    logic        wb;
    logic [2:0]  wreg;
    logic        align;
    logic        dmp;
    logic        hlt;
    logic        notRun;
  } exp_t;

  exp_t expQ[$];
  int   compared   = 0;
  int   mismatched = 0;

  ex_mem_pipe dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .ex_out        (ex_out),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_wb_sel     (ex_wb_sel),
    .ex_write_reg  (ex_write_reg),
    .ex_halt       (ex_halt),
    .flush_in      (flush_in),
    .mem_busy      (mem_busy),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .reg_write     (reg_write),
    .wb_sel        (wb_sel),
    .write_reg     (write_reg),
    .valid_out     (valid_out),
    .align_err     (align_err),
    .dump          (dump),
    .halted        (halted),
    .stall_out     (stall_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [15:0] a, input logic [15:0] d,
                              input logic rd, input logic wr, input logic rw, input logic wb,
                              input logic [2:0] r, input logic al, input logic dm,
                              input logic hl, input logic nr);
    exp_t e;
    e.valid = v;  e.addr = a;   e.wdata = d;  e.rd = rd;   e.wr = wr;  e.rw = rw;
    e.wb = wb;    e.wreg = r;   e.align = al; e.dmp = dm;  e.hlt = hl; e.notRun = nr;
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] o, input logic [15:0] sd,
                       input logic rd, input logic wr, input logic rw, input logic wb,
                       input logic [2:0] wreg, input logic h, input logic fl, input logic bz);
    rst = r;            in_valid = v;       ex_out = o;         ex_store_data = sd;
    ex_mem_read = rd;   ex_mem_write = wr;  ex_reg_write = rw;  ex_wb_sel = wb;
    ex_write_reg = wreg; ex_halt = h;       flush_in = fl;      mem_busy = bz;
  endtask

  // Expectation e describes the DUT outputs after the next rising edge.
  task automatic tick(input exp_t e);
    @(posedge clk);
    #1;
    expQ.push_back(e);
  endtask

  // stall_out is combinational on mem_busy, so its expected value folds in the busy
  // input the bench is applying at the sample point.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      check("valid_out", {31'd0, valid_out}, {31'd0, e.valid});
      check("mem_addr",  {16'd0, mem_addr},  {16'd0, e.addr});
      check("mem_wdata", {16'd0, mem_wdata}, {16'd0, e.wdata});
      check("mem_read",  {31'd0, mem_read},  {31'd0, e.rd});
      check("mem_write", {31'd0, mem_write}, {31'd0, e.wr});
      check("reg_write", {31'd0, reg_write}, {31'd0, e.rw});
      check("wb_sel",    {31'd0, wb_sel},    {31'd0, e.wb});
      check("write_reg", {29'd0, write_reg}, {29'd0, e.wreg});
      check("align_err", {31'd0, align_err}, {31'd0, e.align});
      check("dump",      {31'd0, dump},      {31'd0, e.dmp});
      check("halted",    {31'd0, halted},    {31'd0, e.hlt});
      check("stall_out", {31'd0, stall_out}, {31'd0, (e.notRun | mem_busy)});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t bub;
    exp_t eLoad;
    exp_t eRw;
    exp_t eMis;
    exp_t eHalt;
    exp_t eHlt;
    logic [31:0] r;
    logic [31:0] r2;

    bub   = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
    eHlt  = mk(0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 1, 1);
    eHalt = mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);

    // Reset state
    drive(1, 1, 16'hFFFF, 16'hFFFF, 1, 1, 1, 1, 3'd7, 0, 0, 0);
    tick(bub);
    tick(bub);

    // Aligned store, one-cycle latency
    drive(0, 1, 16'h0040, 16'hBEEF, 0, 1, 0, 0, 3'd0, 0, 0, 0);
    tick(mk(1, 16'h0040, 16'hBEEF, 0, 1, 0, 0, 3'd0, 0, 0, 0, 0));

    // Load entry, then three busy cycles with changing inputs
    eLoad = mk(1, 16'h0010, 16'h1111, 1, 0, 1, 1, 3'd5, 0, 0, 0, 0);
    drive(0, 1, 16'h0010, 16'h1111, 1, 0, 1, 1, 3'd5, 0, 0, 0);
    tick(eLoad);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 16'h2220 + 16'(i), 16'h5550 + 16'(i), 0, 1, 0, 0, 3'(i), 0, 0, 1);
      tick(eLoad);
    end
    eRw = mk(1, 16'h0022, 16'h3333, 0, 0, 1, 0, 3'd2, 0, 0, 0, 0);
    drive(0, 1, 16'h0022, 16'h3333, 0, 0, 1, 0, 3'd2, 0, 0, 0);
    tick(eRw);

    // Flush during hold is remembered and applied once busy drops
    drive(0, 1, 16'h0044, 16'h4444, 1, 0, 0, 0, 3'd1, 0, 1, 1);
    tick(eRw);
    drive(0, 1, 16'h0046, 16'h4646, 1, 0, 0, 0, 3'd1, 0, 0, 0);
    tick(bub);
    drive(0, 1, 16'h0048, 16'h4848, 1, 0, 1, 1, 3'd3, 0, 0, 0);
    tick(mk(1, 16'h0048, 16'h4848, 1, 0, 1, 1, 3'd3, 0, 0, 0, 0));
    drive(0, 1, 16'h0050, 16'h5050, 0, 1, 0, 0, 3'd0, 0, 1, 0);
    tick(bub);

    // Misaligned load: no access, no register write, align_err held while busy
    eMis = mk(1, 16'h0013, 16'h1313, 0, 0, 0, 0, 3'd4, 1, 0, 0, 0);
    drive(0, 1, 16'h0013, 16'h1313, 1, 0, 1, 0, 3'd4, 0, 0, 0);
    tick(eMis);
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 16'h0020, 16'h0000, 0, 1, 1, 1, 3'd6, 0, 0, 1);
      tick(eMis);
    end
    drive(0, 1, 16'h0101, 16'hAAAA, 0, 1, 0, 0, 3'd0, 0, 0, 0);
    tick(mk(1, 16'h0101, 16'hAAAA, 0, 0, 0, 0, 3'd0, 1, 0, 0, 0));
    drive(0, 0, 16'h0013, 16'h0707, 1, 0, 1, 0, 3'd0, 0, 0, 0);
    tick(mk(0, 16'h0013, 16'h0707, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0));

    // HALT: pending one cycle, dump one cycle, then halted forever
    drive(0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 0, 0);
    tick(eHalt);
    drive(0, 1, 16'h0060, 16'h6060, 1, 1, 1, 1, 3'd7, 0, 0, 0);
    tick(mk(1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 1, 0, 1));
    tick(eHlt);
    for (int i = 0; i < 20; i++) begin
      r  = $urandom;
      r2 = $urandom;
      drive(0, r[0], r2[15:0], r2[31:16], r[1], r[2], r[3], r[4], r[7:5], r[8], r[9], r[10]);
      tick(eHlt);
    end

    // Reset out of HALTED
    drive(1, 1, 16'h0080, 16'h8080, 1, 1, 1, 1, 3'd7, 1, 1, 1);
    tick(bub);
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    tick(bub);

    // Reset in HALT_PEND while busy cancels the dump
    drive(0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 0, 0);
    tick(eHalt);
    drive(0, 1, 16'h0090, 16'h9090, 1, 0, 1, 0, 3'd1, 0, 0, 1);
    tick(eHalt);
    drive(1, 1, 16'h0090, 16'h9090, 1, 0, 1, 0, 3'd1, 0, 0, 1);
    tick(bub);
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 0);
    tick(bub);
    tick(bub);

    // A flushed HALT never starts the halt sequence
    drive(0, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 1, 1, 0);
    tick(bub);
    drive(0, 1, 16'h0070, 16'h7070, 0, 1, 0, 0, 3'd0, 0, 0, 0);
    tick(mk(1, 16'h0070, 16'h7070, 0, 1, 0, 0, 3'd0, 0, 0, 0, 0));
    drive(0, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'd0, 0, 0, 0);

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge clk);
    #1;
    if (expQ.size() > 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
